ram_arbiter: RTL
================

Name: ram_arbiter

Overview:
- Two-requester round-robin arbiter and access sequencer for the shared 8x8 single-port `ram` (clk, addr, data_in, we, data_out).
- Sits between the two client blocks and the `ram` instance, and owns all RAM control pins.
- Serialises accesses; one transaction per grant, each completing in fixed latency.
- Uses a req/ack handshake per requester; read data is returned registered with the ack.

Parameters:
- ADDR_W, 3, RAM address width (depth 2**ADDR_W).
- DATA_W, 8, RAM data width.

Ports:
- clk  input  1  system clock, all logic on rising edge.
- rst  input  1  synchronous, active-high reset.
- req0  input  1  requester 0 transaction request; held until ack0.
- we0  input  1  requester 0: 1 = write, 0 = read; stable while req0.
- addr0  input  ADDR_W  requester 0 address; stable while req0.
- wdata0  input  DATA_W  requester 0 write data; stable while req0.
- ack0  output  1  one-cycle completion pulse to requester 0.
- rdata0  output  DATA_W  requester 0 read data; valid when ack0 follows a read.
- req1, we1, addr1, wdata1, ack1, rdata1: same as above, for requester 1.
- ram_addr  output  ADDR_W  to ram.addr.
- ram_data_in  output  DATA_W  to ram.data_in.
- ram_we  output  1  to ram.we.
- ram_data_out  input  DATA_W  from ram.data_out; valid the cycle after ram_addr is sampled.
- busy  output  1  high in ACCESS and RESP.
- owner  output  1  requester of the current or last transaction.

Behaviour:
- One clock domain, clk. Reset (rst) is synchronous and active-high, sampled on the rising edge.
- Reset values:
  - state = IDLE.
  - ack0 = ack1 = 0.
  - rdata0 = rdata1 = 0.
  - ram_addr = 0, ram_data_in = 0, ram_we = 0.
  - busy = 0, owner = 0.
  - Priority pointer favours requester 0.
- FSM states: IDLE, ACCESS, RESP.
- IDLE:
  - Eligible requesters: reqN high AND ackN low in this cycle. This blocks re-service of a requester that has not yet dropped req.
  - None eligible: stay in IDLE.
  - One eligible: grant it.
  - Both eligible: grant the requester that is not `owner`. After reset, grant 0.
  - On grant, latch weN, addrN and wdataN into registers, set owner = N, and go to ACCESS.
- ACCESS (exactly 1 cycle):
  - ram_addr and ram_data_in are driven from the latched registers.
  - ram_we = latched we, decoded combinationally from state.
  - The RAM samples on the closing edge.
  - Next state: RESP.
- RESP (exactly 1 cycle):
  - ram_we = 0; ram_addr is held.
  - On the closing edge: if the transaction was a read, rdata[owner] <= ram_data_out. Writes leave rdata unchanged.
  - ack[owner] <= 1 on the same edge.
  - Next state: IDLE.
- ack is a registered one-cycle pulse, visible in the IDLE cycle after RESP.
- Latency: reqN sampled in cycle T -> ACCESS at T+1 -> RESP at T+2 -> ackN and rdataN visible at T+3.
- Peak throughput: one transaction per 3 cycles.
- The ack cycle is also an IDLE cycle, so the other requester may be granted in that same cycle.
- Read-after-write to the same address, from either requester, returns the new data: transactions are strictly serialised.
- Address is used as-is. There is no wrap or overflow logic, and address 7 is a normal location.
- A req dropped before its grant is simply not serviced. Dropping req after the grant does not abort the transaction; the ack is still issued.
- Reset mid-operation:
  - Next state = IDLE and all acks are cleared; no ack is issued for the aborted transaction.
  - A write whose ACCESS cycle ends on the edge that samples rst still commits to the RAM, because ram_we was high before the edge.
- Requester protocol violation (changing fields while req is high before ack) is outside the contract. Fields are latched at grant only.

Decomposition:
- Shared package `ram_arb_pkg`:
  - State encoding localparams: IDLE = 2'd0, ACCESS = 2'd1, RESP = 2'd2.
  - ADDR_W / DATA_W defaults.
- One natural sub-module, `rr_pick2`: combinational 2-way round-robin selector.
  - Inputs: elig[1:0], last.
  - Outputs: valid, sel.
- FSM, latches and ack/rdata registers stay in `ram_arbiter`.

Test Plan:
- Reset, then req0 write addr 0 data 0x12 -> ram_we high for exactly 1 cycle with ram_addr=0 and ram_data_in=0x12; ack0 pulses 3 cycles after req0 sampled; ack1 stays 0.
- req1 read addr 0 afterwards -> ack1 at T+3 with rdata1=0x12; rdata0 unchanged; ram_we never asserted.
- After reset, req0 (write addr 3, 0x34) and req1 (write addr 7, 0x56) raised in the same cycle -> req0 served first, req1 granted in the ack0 cycle; reads then return 0x34 at addr 3 and 0x56 at addr 7.
- Both held continuously with reads -> grants alternate 0,1,0,1; no requester served twice in a row; each ack is 1 cycle wide.
- rst asserted during RESP of a read by req0 -> ack0 never pulses; state is IDLE the next cycle; rdata0 = 0; busy = 0.
- req0 held high through its ack with req1 idle -> exactly one transaction; a second grant only occurs if req0 is still high in the cycle after ack0.

Source files
------------

// File: rtl/ram_arb_pkg.sv
// Shared definitions for the two-requester RAM arbiter: state encoding and
// default RAM geometry.
package ram_arb_pkg;

  localparam int unsigned DEF_ADDR_W = 3;
  localparam int unsigned DEF_DATA_W = 8;

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] ACCESS = 2'd1;
  localparam logic [1:0] RESP   = 2'd2;

  typedef enum logic [1:0] {
    StIdle   = IDLE,
    StAccess = ACCESS,
    StResp   = RESP
  } state_e;

endpackage

// File: rtl/rr_pick2.sv
// Combinational two-way round-robin selector. On a tie the requester that
// was not picked last wins.
module rr_pick2 (
  input  logic [1:0] elig,
  input  logic       last,
  output logic       valid,
  output logic       sel
);

  // Pick the sole eligible requester, or alternate away from 'last' on a tie
  always_comb begin
    valid = |elig;
    sel   = 1'b0;
    if (&elig) begin
      sel = ~last;
    end else begin
      sel = elig[1];
    end
  end

endmodule

// File: rtl/ram_arbiter.sv
// Round-robin arbiter and access sequencer for a shared single-port RAM.
// Each grant runs IDLE -> ACCESS -> RESP; ack and read data are registered
// and appear in the IDLE cycle that follows RESP.
module ram_arbiter
  import ram_arb_pkg::*;
#(
  parameter int unsigned ADDR_W = DEF_ADDR_W,
  parameter int unsigned DATA_W = DEF_DATA_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0,
  input  logic              we0,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [DATA_W-1:0] wdata0,
  output logic              ack0,
  output logic [DATA_W-1:0] rdata0,
  input  logic              req1,
  input  logic              we1,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata1,
  output logic              ack1,
  output logic [DATA_W-1:0] rdata1,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_data_in,
  output logic              ram_we,
  input  logic [DATA_W-1:0] ram_data_out,
  output logic              busy,
  output logic              owner
);

  state_e            state_q, state_d;
  logic              owner_q;
  // Priority pointer: last granted requester; resets to 1 so 0 wins first tie
  logic              last_q;
  logic              we_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic              ack0_q, ack1_q;
  logic [DATA_W-1:0] rdata0_q, rdata1_q;

  logic [1:0]        elig;
  logic              pick_valid;
  logic              pick_sel;

  // A requester still seeing its ack is not eligible, so a held req is not re-served
  assign elig = {req1 & ~ack1_q, req0 & ~ack0_q};

  rr_pick2 u_pick (
    .elig  (elig),
    .last  (last_q),
    .valid (pick_valid),
    .sel   (pick_sel)
  );

  // Next-state decode for the access sequence
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:   if (pick_valid) state_d = StAccess;
      StAccess: state_d = StResp;
      StResp:   state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  // State, grant latches, ack pulses and read-data capture
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StIdle;
      owner_q  <= 1'b0;
      last_q   <= 1'b1;
      we_q     <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      ack0_q   <= 1'b0;
      ack1_q   <= 1'b0;
      rdata0_q <= '0;
      rdata1_q <= '0;
    end else begin
      state_q <= state_d;
      ack0_q  <= 1'b0;
      ack1_q  <= 1'b0;
      if (state_q == StIdle && pick_valid) begin
        owner_q <= pick_sel;
        last_q  <= pick_sel;
        we_q    <= pick_sel ? we1 : we0;
        addr_q  <= pick_sel ? addr1 : addr0;
        wdata_q <= pick_sel ? wdata1 : wdata0;
      end
      if (state_q == StResp) begin
        if (owner_q) begin
          ack1_q <= 1'b1;
          if (!we_q) rdata1_q <= ram_data_out;
        end else begin
          ack0_q <= 1'b1;
          if (!we_q) rdata0_q <= ram_data_out;
        end
      end
    end
  end

  // RAM pins come straight from the grant latches; write strobe only in ACCESS
  assign ram_addr    = addr_q;
  assign ram_data_in = wdata_q;
  assign ram_we      = (state_q == StAccess) && we_q;

  assign busy   = (state_q != StIdle);
  assign owner  = owner_q;
  assign ack0   = ack0_q;
  assign ack1   = ack1_q;
  assign rdata0 = rdata0_q;
  assign rdata1 = rdata1_q;

endmodule
